// File: rtl/gray_counter_n_if.sv
// Control and status bundle for the N-bit Gray counter.
interface gray_counter_n_if #(
    parameter int unsigned WIDTH = 3
);
    logic             En;
    logic             Dir;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             ClrFlags;
    logic [WIDTH-1:0] Gray;
    logic [WIDTH-1:0] Bin;
    logic             Overflow;
    logic             Underflow;
    logic             Wrap;

    // Driver side: issues commands, observes the count.
    modport master (
        output En, Dir, Load, LoadVal, ClrFlags,
        input  Gray, Bin, Overflow, Underflow, Wrap
    );

    // Counter side.
    modport slave (
        input  En, Dir, Load, LoadVal, ClrFlags,
        output Gray, Bin, Overflow, Underflow, Wrap
    );
endinterface

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with load, wrap/saturate terminal
// behaviour, sticky overflow/underflow flags and a registered wrap pulse.
module gray_counter_n #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input logic              Clk,
    input logic              Reset,
    gray_counter_n_if.slave  bus
);
    localparam logic [WIDTH-1:0] MaxVal = '1;
    localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wrap_q, wrap_d;

    // Next-state: load beats counting; flag clear runs in parallel and loses
    // to a same-edge set of that flag.
    always_comb begin
        bin_d  = bin_q;
        ovf_d  = ovf_q & ~bus.ClrFlags;
        unf_d  = unf_q & ~bus.ClrFlags;
        wrap_d = 1'b0;
        if (bus.Load) begin
            bin_d = bus.LoadVal;
        end else if (bus.En) begin
            if (bus.Dir) begin
                if (bin_q == MaxVal) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) begin
                        bin_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q + One;
                end
            end else begin
                if (bin_q == '0) begin
                    unf_d = 1'b1;
                    if (!SATURATE) begin
                        bin_d  = MaxVal;
                        wrap_d = 1'b1;
                    end
                end else begin
                    bin_d = bin_q - One;
                end
            end
        end
        // Gray is registered from the same next binary value, so both outputs
        // always agree.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrap_q <= wrap_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.Bin       = bin_q;
        bus.Gray      = gray_q;
        bus.Overflow  = ovf_q;
        bus.Underflow = unf_q;
        bus.Wrap      = wrap_q;
    end
endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: three instances (3-bit wrap, 3-bit
// saturate, 8-bit wrap) checked against a scoreboard of expected states.
module tb_gray_counter_n;
    logic Clk;
    logic Reset;

    typedef struct packed {
        logic [15:0] bin;
        logic        ovf;
        logic        unf;
        logic        wrap;
    } st_t;

    typedef struct {
        int  dut;
        int  step;
        st_t st;
    } sb_t;

    sb_t  sbq[$];
    st_t  m[3];
    int   checks;
    int   errors;
    int   step_no;

    gray_counter_n_if #(.WIDTH(3)) a3_if ();
    gray_counter_n_if #(.WIDTH(3)) s3_if ();
    gray_counter_n_if #(.WIDTH(8)) b8_if ();

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u_a3 (.Clk(Clk), .Reset(Reset), .bus(a3_if));
    gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) u_s3 (.Clk(Clk), .Reset(Reset), .bus(s3_if));
    gray_counter_n #(.WIDTH(8), .SATURATE(1'b0)) u_b8 (.Clk(Clk), .Reset(Reset), .bus(b8_if));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference behaviour of one edge, independent of the RTL structure.
    function automatic st_t model(st_t s, int unsigned w, bit sat, bit rst, bit ld,
                                  logic [15:0] lv, bit en, bit dir, bit clr);
        st_t         n;
        logic [15:0] mx;
        mx = 16'((32'd1 << w) - 32'd1);
        n = s;
        n.wrap = 1'b0;
        if (clr) begin
            n.ovf = 1'b0;
            n.unf = 1'b0;
        end
        if (rst) return '0;
        if (ld) begin
            n.bin = lv & mx;
        end else if (en) begin
            if (dir) begin
                if (s.bin == mx) begin
                    n.ovf = 1'b1;
                    if (!sat) begin
                        n.bin  = '0;
                        n.wrap = 1'b1;
                    end
                end else begin
                    n.bin = s.bin + 16'd1;
                end
            end else begin
                if (s.bin == 16'd0) begin
                    n.unf = 1'b1;
                    if (!sat) begin
                        n.bin  = mx;
                        n.wrap = 1'b1;
                    end
                end else begin
                    n.bin = s.bin - 16'd1;
                end
            end
        end
        return n;
    endfunction

    function automatic st_t observed(int d);
        st_t o;
        case (d)
            0: o = '{16'(a3_if.Bin), a3_if.Overflow, a3_if.Underflow, a3_if.Wrap};
            1: o = '{16'(s3_if.Bin), s3_if.Overflow, s3_if.Underflow, s3_if.Wrap};
            default: o = '{16'(b8_if.Bin), b8_if.Overflow, b8_if.Underflow, b8_if.Wrap};
        endcase
        return o;
    endfunction

    function automatic logic [15:0] observed_gray(int d);
        case (d)
            0: return 16'(a3_if.Gray);
            1: return 16'(s3_if.Gray);
            default: return 16'(b8_if.Gray);
        endcase
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        a3_if.En = 0; a3_if.Dir = 0; a3_if.Load = 0; a3_if.LoadVal = '0; a3_if.ClrFlags = 0;
        s3_if.En = 0; s3_if.Dir = 0; s3_if.Load = 0; s3_if.LoadVal = '0; s3_if.ClrFlags = 0;
        b8_if.En = 0; b8_if.Dir = 0; b8_if.Load = 0; b8_if.LoadVal = '0; b8_if.ClrFlags = 0;
    endtask

    // Push expectations for the applied inputs, clock once, then pop and
    // compare every instance.
    task automatic cycle();
        sb_t e;
        m[0] = model(m[0], 3, 1'b0, Reset, a3_if.Load, 16'(a3_if.LoadVal), a3_if.En,
                     a3_if.Dir, a3_if.ClrFlags);
        m[1] = model(m[1], 3, 1'b1, Reset, s3_if.Load, 16'(s3_if.LoadVal), s3_if.En,
                     s3_if.Dir, s3_if.ClrFlags);
        m[2] = model(m[2], 8, 1'b0, Reset, b8_if.Load, 16'(b8_if.LoadVal), b8_if.En,
                     b8_if.Dir, b8_if.ClrFlags);
        for (int d = 0; d < 3; d++) sbq.push_back('{d, step_no, m[d]});
        @(posedge Clk);
        #1;
        while (sbq.size() > 0) begin
            st_t o;
            e = sbq.pop_front();
            o = observed(e.dut);
            chk($sformatf("s%0d.d%0d.bin", e.step, e.dut), o.bin, e.st.bin);
            chk($sformatf("s%0d.d%0d.gray", e.step, e.dut), observed_gray(e.dut),
                e.st.bin ^ (e.st.bin >> 1));
            chk($sformatf("s%0d.d%0d.flags", e.step, e.dut), {13'd0, o.ovf, o.unf, o.wrap},
                {13'd0, e.st.ovf, e.st.unf, e.st.wrap});
        end
        step_no++;
    endtask

    logic [2:0]  gseq [9];
    logic [15:0] prev_gray;

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        for (int d = 0; d < 3; d++) m[d] = '0;
        gseq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
        idle_all();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        chk("rst.a3.gray", 16'(a3_if.Gray), 16'd0);
        chk("rst.b8.bin", 16'(b8_if.Bin), 16'd0);

        // Up-count through a full wrap on the 3-bit wrap instance.
        a3_if.En = 1; a3_if.Dir = 1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk($sformatf("t1.gray%0d", i), 16'(a3_if.Gray), 16'(gseq[i]));
            chk($sformatf("t1.ovf%0d", i), 16'(a3_if.Overflow), 16'(i >= 7));
            chk($sformatf("t1.wrap%0d", i), 16'(a3_if.Wrap), 16'(i == 7));
        end

        // Down-step from zero wraps to max.
        idle_all();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        a3_if.En = 1; a3_if.Dir = 0;
        cycle();
        chk("t2.bin", 16'(a3_if.Bin), 16'd7);
        chk("t2.gray", 16'(a3_if.Gray), 16'b100);
        chk("t2.flags", {a3_if.Overflow, a3_if.Underflow, a3_if.Wrap}, 16'b011);
        cycle();
        chk("t2.bin2", 16'(a3_if.Bin), 16'd6);
        chk("t2.gray2", 16'(a3_if.Gray), 16'b101);
        chk("t2.wrap2", 16'(a3_if.Wrap), 16'd0);

        // Load wins over a simultaneous up-step; flags untouched.
        a3_if.Load = 1; a3_if.LoadVal = 3'd5; a3_if.Dir = 1;
        cycle();
        chk("t3.bin", 16'(a3_if.Bin), 16'd5);
        chk("t3.gray", 16'(a3_if.Gray), 16'b111);
        chk("t3.flags", {a3_if.Overflow, a3_if.Underflow}, 16'b01);
        a3_if.Load = 0;
        cycle();
        chk("t3.bin2", 16'(a3_if.Bin), 16'd6);
        chk("t3.gray2", 16'(a3_if.Gray), 16'b101);

        // Saturating instance holds at both ends.
        idle_all();
        s3_if.Load = 1; s3_if.LoadVal = 3'd7;
        cycle();
        s3_if.Load = 0; s3_if.En = 1; s3_if.Dir = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("t4.bin", 16'(s3_if.Bin), 16'd7);
            chk("t4.gray", 16'(s3_if.Gray), 16'b100);
            chk("t4.ovf", 16'(s3_if.Overflow), 16'd1);
            chk("t4.wrap", 16'(s3_if.Wrap), 16'd0);
        end
        s3_if.En = 0; s3_if.Load = 1; s3_if.LoadVal = 3'd0;
        cycle();
        s3_if.Load = 0; s3_if.En = 1; s3_if.Dir = 0;
        cycle();
        chk("t4.bin0", 16'(s3_if.Bin), 16'd0);
        chk("t4.unf", 16'(s3_if.Underflow), 16'd1);
        chk("t4.wrap0", 16'(s3_if.Wrap), 16'd0);

        // Same-edge overflow beats ClrFlags; underflow still clears.
        idle_all();
        a3_if.Load = 1; a3_if.LoadVal = 3'd7;
        cycle();
        a3_if.Load = 0; a3_if.En = 1; a3_if.Dir = 1;
        cycle();
        a3_if.En = 0; a3_if.Load = 1; a3_if.LoadVal = 3'd7;
        cycle();
        chk("t5.pre", {a3_if.Overflow, a3_if.Underflow}, 16'b11);
        a3_if.Load = 0; a3_if.En = 1; a3_if.Dir = 1; a3_if.ClrFlags = 1;
        cycle();
        chk("t5.ovf", 16'(a3_if.Overflow), 16'd1);
        chk("t5.unf", 16'(a3_if.Underflow), 16'd0);
        chk("t5.wrap", 16'(a3_if.Wrap), 16'd1);
        a3_if.En = 0;
        cycle();
        chk("t5.clr", 16'(a3_if.Overflow), 16'd0);

        // 8-bit: reset mid-count, then a full free-run cycle.
        idle_all();
        b8_if.Load = 1; b8_if.LoadVal = 8'h9B;
        cycle();
        b8_if.Load = 0; b8_if.En = 1; b8_if.Dir = 1;
        cycle();
        chk("t6.mid", 16'(b8_if.Bin), 16'h9C);
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
        chk("t6.rst", {b8_if.Bin, b8_if.Gray}, 16'd0);
        chk("t6.rstf", {b8_if.Overflow, b8_if.Underflow, b8_if.Wrap}, 16'd0);
        prev_gray = 16'(b8_if.Gray);
        for (int i = 0; i < 256; i++) begin
            cycle();
            chk("t6.ham", 16'($countones(prev_gray ^ 16'(b8_if.Gray))), 16'd1);
            chk("t6.enc", 16'(b8_if.Gray), 16'(b8_if.Bin ^ (b8_if.Bin >> 1)));
            prev_gray = 16'(b8_if.Gray);
        end
        chk("t6.end", 16'(b8_if.Bin), 16'd0);
        chk("t6.ovf", 16'(b8_if.Overflow), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
